// File: rtl/lfsr_checker_if.sv
// Serial PRBS checker bus: received bit, control and status.
// The master side drives the stream; the slave side is the checker.
interface lfsr_checker_if #(
  parameter int nbits = 8,
  parameter int cbits = 16
);
  logic             en;
  logic [nbits-1:0] tap;
  logic             clr;
  logic             in;
  logic             locked;
  logic             err;
  logic [cbits-1:0] err_count;
  logic [cbits-1:0] bit_count;

  modport master (output en, tap, clr, in,
                  input  locked, err, err_count, bit_count);
  modport slave  (input  en, tap, clr, in,
                  output locked, err, err_count, bit_count);
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronizing serial PRBS checker with saturating error/bit counters.
// Define LFSR_CHECKER_RESYNC_EN to add window/threshold loss-of-sync detection.
module lfsr_checker #(
  parameter int nbits  = 8,
  parameter int cbits  = 16,
  parameter int win    = 32,
  parameter int thresh = 8
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave bus
);
  typedef enum logic {FILL, CHECK} state_t;

  localparam int FW = $clog2(nbits + 1);

  if (nbits < 2 || win < 4 || (win & (win - 1)) != 0 || thresh < 1 || thresh > win)
  begin : g_bad_params
    $error("lfsr_checker: illegal parameter combination");
  end

  state_t           state, state_d;
  logic [nbits-1:0] sr;
  logic [FW-1:0]    fill_cnt;
  logic [cbits-1:0] err_count, bit_count;
  logic             err;
  logic             p, chk, miss, fill_done, trip;

  // Forcing mask bit 0 high folds q[0] into the feedback and ignores tap[0].
  assign p         = ^(sr & (bus.tap | nbits'(1)));
  assign chk       = (state == CHECK) && bus.en;
  assign miss      = chk && (bus.in != p);
  assign fill_done = (state == FILL) && bus.en && (fill_cnt == FW'(nbits - 1));

`ifdef LFSR_CHECKER_RESYNC_EN
  localparam int WW = $clog2(win);
  localparam int EW = $clog2(win + 1);

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;

  assign trip = miss && (win_err == EW'(thresh - 1));

  // win is a power of two, so win_cnt wraps naturally at the window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (fill_done || trip) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (chk) begin
      win_cnt <= win_cnt + WW'(1);
      win_err <= (&win_cnt) ? '0 : win_err + EW'(miss);
    end
  end
`else
  assign trip = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      FILL:    if (fill_done) state_d = CHECK;
      CHECK:   if (trip)      state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  // Predicted bit is shifted in while checking so a line error cannot propagate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      fill_cnt <= '0;
    end else if (bus.en) begin
      if (state == FILL) begin
        sr       <= {bus.in, sr[nbits-1:1]};
        fill_cnt <= fill_done ? '0 : fill_cnt + FW'(1);
      end else begin
        sr       <= {p, sr[nbits-1:1]};
        fill_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err <= miss;
      if (bus.clr) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (chk) begin
        if (!(&bit_count))        bit_count <= bit_count + cbits'(1);
        if (miss && !(&err_count)) err_count <= err_count + cbits'(1);
      end
    end
  end

  assign bus.locked    = (state == CHECK);
  assign bus.err       = err;
  assign bus.err_count = err_count;
  assign bus.bit_count = bit_count;
endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: reference generator drives two checkers
// (16-bit and 4-bit counters); expected err bits are queued per driven cycle.
module tb_lfsr_checker;
  localparam logic [7:0] TAP = 8'hB8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_checker_if #(.nbits(8), .cbits(16)) b0();
  lfsr_checker_if #(.nbits(8), .cbits(4))  b1();

  lfsr_checker #(.nbits(8), .cbits(16), .win(32), .thresh(8)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  lfsr_checker #(.nbits(8), .cbits(4), .win(32), .thresh(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  int   errors = 0;
  int   checks = 0;
  bit   sbq[$];
  logic [7:0] g;

  function automatic bit gen_next();
    bit o, fb;
    o  = g[0];
    fb = g[0] ^ (^(g[7:1] & TAP[7:1]));
    g  = {fb, g[7:1]};
    return o;
  endfunction

  task automatic set_in(input bit en_v, input bit in_v, input bit clr_v);
    b0.en = en_v; b0.in = in_v; b0.clr = clr_v; b0.tap = TAP;
    b1.en = en_v; b1.in = in_v; b1.clr = clr_v; b1.tap = TAP;
  endtask

  task automatic drive(input bit en_v, input bit in_v, input bit clr_v, input bit exp_err);
    set_in(en_v, in_v, clr_v);
    sbq.push_back(exp_err);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    set_in(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic relock(input string tag);
    bit e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, gen_next(), 1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin
        errors++; $display("FAIL %s_fill_err bit %0d: got %b want %b", tag, i, b0.err, e);
      end
      checks++;
      if (b0.locked !== (i == 7)) begin
        errors++; $display("FAIL %s_locked fill bit %0d: got %b want %b", tag, i, b0.locked, (i == 7));
      end
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (b0.locked !== 1'b0)     begin errors++; $display("FAIL reset_locked: got %b want 0", b0.locked); end
    if (b0.err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b want 0", b0.err); end
    if (b0.err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", b0.err_count); end
    if (b0.bit_count !== 16'd0) begin errors++; $display("FAIL reset_bit_count: got %0d want 0", b0.bit_count); end
    if (b1.bit_count !== 4'd0)  begin errors++; $display("FAIL reset_bit_count4: got %0d want 0", b1.bit_count); end
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic test_lock();
    bit e;
    apply_reset();
    g = 8'h01;
    relock("lock");
    for (int i = 0; i < 292; i++) begin
      drive(1'b1, gen_next(), 1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin errors++; $display("FAIL lock_err bit %0d: got %b want %b", i, b0.err, e); end
    end
    checks += 4;
    if (b0.err_count !== 16'd0)   begin errors++; $display("FAIL lock_err_count: got %0d want 0", b0.err_count); end
    if (b0.bit_count !== 16'd292) begin errors++; $display("FAIL lock_bit_count: got %0d want 292", b0.bit_count); end
    if (b1.bit_count !== 4'd15)   begin errors++; $display("FAIL lock_bit_count_sat: got %0d want 15", b1.bit_count); end
    if (b0.locked !== 1'b1)       begin errors++; $display("FAIL lock_locked: got %b want 1", b0.locked); end
  endtask

  task automatic test_flip();
    bit e, f, b;
    int pulses = 0, unlocked = 0;
    apply_reset();
    g = 8'h01;
    relock("flip");
    for (int i = 0; i < 150; i++) begin
      b = gen_next();
      f = (i == 100);
      drive(1'b1, b ^ f, 1'b0, f);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin errors++; $display("FAIL flip_err bit %0d: got %b want %b", i, b0.err, e); end
      if (b0.err === 1'b1) pulses++;
      if (b0.locked !== 1'b1) unlocked++;
    end
    checks += 4;
    if (pulses !== 1)             begin errors++; $display("FAIL flip_pulses: got %0d want 1", pulses); end
    if (unlocked !== 0)           begin errors++; $display("FAIL flip_unlocked_cycles: got %0d want 0", unlocked); end
    if (b0.err_count !== 16'd1)   begin errors++; $display("FAIL flip_err_count: got %0d want 1", b0.err_count); end
    if (b0.bit_count !== 16'd150) begin errors++; $display("FAIL flip_bit_count: got %0d want 150", b0.bit_count); end
  endtask

  task automatic test_loss_sync();
    bit e, gb, r, m;
    int nerr = 0, nbits_chk = 0;
    bit dropped = 1'b0;
    apply_reset();
    g = 8'h01;
    relock("loss");
`ifdef LFSR_CHECKER_RESYNC_EN
    for (int i = 0; i < 32 && !dropped; i++) begin
      gb = gen_next();
      r  = 1'($urandom_range(0, 1));
      m  = r ^ gb;
      nerr += int'(m);
      nbits_chk++;
      drive(1'b1, r, 1'b0, m);
      e = sbq.pop_front();
      checks += 2;
      if (b0.err !== e) begin errors++; $display("FAIL loss_err bit %0d: got %b want %b", i, b0.err, e); end
      if (b0.locked !== (nerr < 8)) begin
        errors++; $display("FAIL loss_locked bit %0d: got %b want %b", i, b0.locked, (nerr < 8));
      end
      if (nerr >= 8) dropped = 1'b1;
    end
    checks++;
    if (!dropped) begin errors++; $display("FAIL loss_drop: errors in 32 bits %0d want >= 8", nerr); end
    relock("resync");
`else
    for (int i = 0; i < 64; i++) begin
      gb = gen_next();
      r  = 1'($urandom_range(0, 1));
      m  = r ^ gb;
      nerr += int'(m);
      nbits_chk++;
      drive(1'b1, r, 1'b0, m);
      e = sbq.pop_front();
      checks += 2;
      if (b0.err !== e) begin errors++; $display("FAIL loss_err bit %0d: got %b want %b", i, b0.err, e); end
      if (b0.locked !== 1'b1) begin errors++; $display("FAIL loss_locked bit %0d: got %b want 1", i, b0.locked); end
    end
`endif
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, gen_next(), 1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin errors++; $display("FAIL loss_clean_err bit %0d: got %b want %b", i, b0.err, e); end
    end
    checks += 3;
    if (b0.err_count !== 16'(nerr)) begin errors++; $display("FAIL loss_err_count: got %0d want %0d", b0.err_count, nerr); end
    if (b0.bit_count !== 16'(nbits_chk + 20)) begin
      errors++; $display("FAIL loss_bit_count: got %0d want %0d", b0.bit_count, nbits_chk + 20);
    end
    if (b0.locked !== 1'b1) begin errors++; $display("FAIL loss_relocked: got %b want 1", b0.locked); end
  endtask

  task automatic test_gaps_clear();
    bit e, b, f;
    apply_reset();
    g = 8'h01;
    relock("gaps");
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        b = gen_next();
        f = (i == 40);
        drive(1'b1, b ^ f, 1'b0, f);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      e = sbq.pop_front();
      checks += 2;
      if (b0.err !== e) begin errors++; $display("FAIL gaps_err cycle %0d: got %b want %b", i, b0.err, e); end
      if (b0.bit_count !== 16'(i / 2 + 1)) begin
        errors++; $display("FAIL gaps_bit_count cycle %0d: got %0d want %0d", i, b0.bit_count, i / 2 + 1);
      end
    end
    checks++;
    if (b0.err_count !== 16'd1) begin errors++; $display("FAIL gaps_err_count: got %0d want 1", b0.err_count); end
    b = gen_next();
    drive(1'b1, ~b, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks += 3;
    if (b0.err !== e)           begin errors++; $display("FAIL clr_err: got %b want %b", b0.err, e); end
    if (b0.err_count !== 16'd0) begin errors++; $display("FAIL clr_err_count: got %0d want 0", b0.err_count); end
    if (b0.bit_count !== 16'd0) begin errors++; $display("FAIL clr_bit_count: got %0d want 0", b0.bit_count); end
    drive(1'b1, gen_next(), 1'b0, 1'b0);
    e = sbq.pop_front();
    checks += 3;
    if (b0.err !== e)           begin errors++; $display("FAIL post_clr_err: got %b want %b", b0.err, e); end
    if (b0.err_count !== 16'd0) begin errors++; $display("FAIL post_clr_err_count: got %0d want 0", b0.err_count); end
    if (b0.bit_count !== 16'd1) begin errors++; $display("FAIL post_clr_bit_count: got %0d want 1", b0.bit_count); end
  endtask

  task automatic test_saturation();
    bit e, b, f;
    apply_reset();
    g = 8'h01;
    relock("sat");
    // Flips every 5th bit: never more than 7 in any 32-bit window.
    for (int i = 0; i < 100; i++) begin
      b = gen_next();
      f = (i % 5 == 0);
      drive(1'b1, b ^ f, 1'b0, f);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin errors++; $display("FAIL sat_err bit %0d: got %b want %b", i, b0.err, e); end
    end
    checks += 5;
    if (b1.err_count !== 4'd15)   begin errors++; $display("FAIL sat_err_count4: got %0d want 15", b1.err_count); end
    if (b1.bit_count !== 4'd15)   begin errors++; $display("FAIL sat_bit_count4: got %0d want 15", b1.bit_count); end
    if (b0.err_count !== 16'd20)  begin errors++; $display("FAIL sat_err_count16: got %0d want 20", b0.err_count); end
    if (b0.bit_count !== 16'd100) begin errors++; $display("FAIL sat_bit_count16: got %0d want 100", b0.bit_count); end
    if (b0.locked !== 1'b1)       begin errors++; $display("FAIL sat_locked: got %b want 1", b0.locked); end
  endtask

  task automatic test_reset_mid();
    bit e;
    int pulses = 0;
    set_in(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (b0.locked !== 1'b0)     begin errors++; $display("FAIL rstmid_locked: got %b want 0", b0.locked); end
    if (b0.err !== 1'b0)        begin errors++; $display("FAIL rstmid_err: got %b want 0", b0.err); end
    if (b0.err_count !== 16'd0) begin errors++; $display("FAIL rstmid_err_count: got %0d want 0", b0.err_count); end
    if (b0.bit_count !== 16'd0) begin errors++; $display("FAIL rstmid_bit_count: got %0d want 0", b0.bit_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    relock("rstmid");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, gen_next(), 1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (b0.err !== e) begin errors++; $display("FAIL rstmid_err bit %0d: got %b want %b", i, b0.err, e); end
      if (b0.err === 1'b1) pulses++;
    end
    checks += 2;
    if (pulses !== 0)            begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
    if (b0.bit_count !== 16'd10) begin errors++; $display("FAIL rstmid_bit_count_after: got %0d want 10", b0.bit_count); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    void'($urandom(32'h1234_5678));
    test_reset();
    test_lock();
    test_flip();
    test_loss_sync();
    test_gaps_clear();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
